sample_edl_stage: RTL and testbench
===================================

Name: sample_edl_stage

Overview:
Clocked error-detecting capture stage on the datapath fed by the sample controller.
- Captures a word, then checks it one cycle later against a shadow copy of the same data.
- On mismatch, substitutes the shadow value, stalls for recovery and flags the error.
- Passes verified words downstream over a valid/ready handshake.

Parameters:
WIDTH, 8, data word width in bits
RECOVERY_CYCLES, 1, stall cycles spent in RECOVER after a mismatch (legal range 1..15)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  upstream word present
in_ready  output  1  stage accepts a word this cycle
in_data  input  WIDTH  main-sampled data word
shadow_d  input  WIDTH  delayed (shadow) sample of the same data, valid in the cycle after acceptance
out_valid  output  1  verified word available
out_ready  input  1  downstream accepts the word
out_data  output  WIDTH  verified word
err_pulse  output  1  one-cycle pulse per detected mismatch
err_count  output  CNT_W  saturating count of mismatches since reset

Behaviour:
Reset values:
- rst asserted (asynchronously) forces state=IDLE.
- out_valid=0, out_data=0, err_pulse=0, err_count=0, recovery counter=0 and internal main_q=0.
- Reset mid-transaction discards the in-flight word; no output handshake occurs for it.

State machine (states IDLE, CHECK, RECOVER, HOLD):
- IDLE: in_ready=1. If in_valid, main_q<=in_data and go to CHECK.
- CHECK: in_ready=0. Compare main_q with shadow_d.
  - Equal: out_data<=main_q, out_valid<=1, go to HOLD.
  - Unequal: main_q<=shadow_d, err_pulse<=1 (next cycle only), err_count<=err_count+1 saturating at all-ones, load recovery counter with RECOVERY_CYCLES-1, go to RECOVER.
- RECOVER: in_ready=0, out_valid=0. Counter decrements each cycle. When the counter is 0: out_data<=main_q, out_valid<=1, go to HOLD.
- HOLD: out_valid=1 and out_data stable until out_ready=1.
  - Handshake with in_valid=1 in the same cycle: main_q<=in_data, out_valid<=0, go to CHECK (back-to-back throughput).
  - Handshake without in_valid: out_valid<=0, go to IDLE.

Ready and latency:
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This is combinational from out_ready; that is the only combinational in-to-out path.
- Latency without error: acceptance edge to out_valid=1 is 2 cycles (IDLE->CHECK->HOLD).
- Latency with error: 2+RECOVERY_CYCLES cycles.
- Peak throughput is one word per 2 cycles.

Boundary conditions:
- err_count at max stays at max; err_pulse still fires.
- shadow_d is ignored in every state except CHECK.
- in_valid while in_ready=0 is held off; upstream must keep in_data stable until accepted.
- out_ready while out_valid=0 has no effect.

Optional Feature:
Macro SAMPLE_EDL_ERRLOG_EN.
- Defined: adds outputs err_log_main (WIDTH) and err_log_shadow (WIDTH), plus err_log_valid (1).
  - On the first mismatch after reset, they capture main_q and shadow_d and set err_log_valid=1.
  - Later mismatches do not overwrite them. All three reset to 0.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package sample_edl_pkg holds:
  - state enum (IDLE=2'd0, CHECK=2'd1, RECOVER=2'd2, HOLD=2'd3);
  - saturating-increment function;
  - default WIDTH and CNT_W constants.
- One natural sub-module: sample_edl_satcnt (saturating error counter, inputs clk, rst, inc; output count).

Test Plan:
- Clean word: accept in_data=8'hA5 with shadow_d=8'hA5 -> out_valid at cycle +2, out_data=8'hA5, err_pulse never asserts, err_count=0.
- Mismatch: in_data=8'h3C, shadow_d=8'h3D, RECOVERY_CYCLES=1 -> err_pulse high for exactly 1 cycle, err_count=1, out_data=8'h3D at cycle +3.
- Back-to-back: out_ready held 1 and in_valid held 1 with words 1,2,3 -> a word delivered every 2 cycles in order, and in_ready pulses in the HOLD handshake cycles.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid and out_data stable, in_ready=0 throughout, no new word accepted.
- Saturation: CNT_W=2 with 5 consecutive mismatches -> err_count sequence 1,2,3,3,3 and 5 err_pulses.
- Reset mid-RECOVER: assert rst asynchronously -> all outputs 0 immediately, no out_valid for the aborted word; with SAMPLE_EDL_ERRLOG_EN, err_log_valid=0 after reset.

Source files
------------

// File: rtl/sample_edl_pkg.sv
// rtl/sample_edl_pkg.sv - shared states, defaults and saturating increment for sample_edl_stage
package sample_edl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    RECOVER = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sample_edl_satcnt.sv
// rtl/sample_edl_satcnt.sv - saturating mismatch counter, sticks at all-ones
module sample_edl_satcnt
  import sample_edl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [31:0] MAX_V = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      inc_v;

  assign inc_v = sat_inc(32'(count_q), MAX_V);

  always_comb begin
    count_d = count_q;
    if (inc) count_d = CNT_W'(inc_v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/sample_edl_stage.sv
// rtl/sample_edl_stage.sv - error-detecting capture stage with shadow compare and recovery stall
// Optional first-mismatch log ports enabled by SAMPLE_EDL_ERRLOG_EN.
module sample_edl_stage
  import sample_edl_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int RECOVERY_CYCLES = 1,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] shadow_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
`ifdef SAMPLE_EDL_ERRLOG_EN
  ,
  output logic [WIDTH-1:0] err_log_main,
  output logic [WIDTH-1:0] err_log_shadow,
  output logic             err_log_valid
`endif
);

  localparam logic [3:0] RC_LOAD = 4'(RECOVERY_CYCLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic             mismatch;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_pulse_d = 1'b0;
    rcnt_d      = rcnt_q;
    mismatch    = 1'b0;
    in_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          main_d  = in_data;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (main_q == shadow_d) begin
          out_data_d  = main_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          // The shadow sample is trusted; it replaces the main capture.
          mismatch    = 1'b1;
          main_d      = shadow_d;
          err_pulse_d = 1'b1;
          rcnt_d      = RC_LOAD;
          state_d     = RECOVER;
        end
      end
      RECOVER: begin
        out_valid_d = 1'b0;
        if (rcnt_q == 4'd0) begin
          out_data_d  = main_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            main_d  = in_data;
            state_d = CHECK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      main_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      rcnt_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_pulse_q <= err_pulse_d;
      rcnt_q      <= rcnt_d;
    end
  end

  sample_edl_satcnt #(.CNT_W(CNT_W)) u_satcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mismatch),
    .count (err_count)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_pulse = err_pulse_q;

`ifdef SAMPLE_EDL_ERRLOG_EN
  logic [WIDTH-1:0] log_main_q, log_shadow_q;
  logic             log_valid_q;

  // Only the first mismatch since reset is recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_main_q   <= '0;
      log_shadow_q <= '0;
      log_valid_q  <= 1'b0;
    end else if (mismatch && !log_valid_q) begin
      log_main_q   <= main_q;
      log_shadow_q <= shadow_d;
      log_valid_q  <= 1'b1;
    end
  end

  assign err_log_main   = log_main_q;
  assign err_log_shadow = log_shadow_q;
  assign err_log_valid  = log_valid_q;
`endif

endmodule

// File: tb/tb_sample_edl_stage.sv
// tb/tb_sample_edl_stage.sv - scoreboard bench for sample_edl_stage
module tb_sample_edl_stage;

  localparam int W  = 8;
  localparam int RC = 1;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  shadow_d = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          err_pulse;
  logic [CW-1:0] err_count;
`ifdef SAMPLE_EDL_ERRLOG_EN
  logic [W-1:0]  err_log_main;
  logic [W-1:0]  err_log_shadow;
  logic          err_log_valid;
`endif

  sample_edl_stage #(.WIDTH(W), .RECOVERY_CYCLES(RC), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shadow_d  (shadow_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_pulse (err_pulse),
    .err_count (err_count)
`ifdef SAMPLE_EDL_ERRLOG_EN
    ,
    .err_log_main   (err_log_main),
    .err_log_shadow (err_log_shadow),
    .err_log_valid  (err_log_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int pulse_count = 0;
  logic [W-1:0]  exp_data_q[$];
  logic [CW-1:0] exp_cnt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor: every handshake and every err_pulse is matched to the scoreboard.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_count++;
      if (exp_data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual=%0h required=none", out_data);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_data_q.pop_front()));
      end
    end
    if (err_pulse === 1'b1) begin
      pulse_count++;
      if (exp_cnt_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL err_pulse_unexpected actual=%0h required=none", err_count);
      end else begin
        check("err_count_at_pulse", 32'(err_count), 32'(exp_cnt_q.pop_front()));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] s,
                      output int waits, output logic ov_at_accept);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 20) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d required=<20", waits);
    end
    ov_at_accept = out_valid;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    shadow_d = s;
  endtask

  initial begin
    int   w;
    logic ov;
    int   p0;
    int   h0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
`ifdef SAMPLE_EDL_ERRLOG_EN
    check("rst_log_valid", 32'(err_log_valid), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Clean word, observed with out_ready low to see the latency and hold.
    out_ready = 1'b0;
    exp_data_q.push_back(8'hA5);
    send(8'hA5, 8'hA5, w, ov);
    @(negedge clk);
    check("clean_lat_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("clean_lat_c2_valid", 32'(out_valid), 32'd1);
    check("clean_lat_c2_data", 32'(out_data), 32'hA5);
    check("clean_no_pulse", 32'(pulse_count), 32'd0);
    check("clean_err_count", 32'(err_count), 32'd0);

    // Backpressure with a pending upstream word.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    shadow_d = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'hA5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("after_hs_valid", 32'(out_valid), 32'd0);
    check("after_hs_in_ready", 32'(in_ready), 32'd1);
    check("bp_hs_count", 32'(hs_count), 32'd1);
    @(posedge clk);
    #1;

    // Mismatch with one recovery cycle.
    exp_data_q.push_back(8'h3D);
    exp_cnt_q.push_back(2'd1);
    send(8'h3C, 8'h3D, w, ov);
    @(negedge clk);
    check("mm_check_valid", 32'(out_valid), 32'd0);
    check("mm_check_pulse", 32'(err_pulse), 32'd0);
    @(negedge clk);
    check("mm_rec_pulse", 32'(err_pulse), 32'd1);
    check("mm_rec_count", 32'(err_count), 32'd1);
    check("mm_rec_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("mm_hold_valid", 32'(out_valid), 32'd1);
    check("mm_hold_data", 32'(out_data), 32'h3D);
    check("mm_pulse_width", 32'(err_pulse), 32'd0);
`ifdef SAMPLE_EDL_ERRLOG_EN
    check("log_valid", 32'(err_log_valid), 32'd1);
    check("log_main", 32'(err_log_main), 32'h3C);
    check("log_shadow", 32'(err_log_shadow), 32'h3D);
`endif
    @(posedge clk);
    #1;

    // Back-to-back words 1,2,3.
    for (int i = 1; i <= 3; i++) begin
      exp_data_q.push_back(8'(i));
      send(8'(i), 8'(i), w, ov);
      if (i > 1) begin
        check("b2b_wait_cycles", 32'(w), 32'd1);
        check("b2b_accept_in_hold", 32'(ov), 32'd1);
      end
    end
    repeat (3) @(negedge clk);
    check("b2b_hs_count", 32'(hs_count), 32'd5);
    @(posedge clk);
    #1;

    // Saturation from a fresh reset.
    rst = 1'b1;
    #2;
    check("sat_rst_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = pulse_count;
    for (int i = 0; i < 5; i++) begin
      exp_data_q.push_back(8'(8'h80 + i));
      exp_cnt_q.push_back((i < 3) ? CW'(i + 1) : CW'(3));
      send(8'(8'h10 + i), 8'(8'h80 + i), w, ov);
    end
    repeat (3) @(negedge clk);
    check("sat_pulses", 32'(pulse_count - p0), 32'd5);
    check("sat_final_count", 32'(err_count), 32'd3);
`ifdef SAMPLE_EDL_ERRLOG_EN
    check("sat_log_main", 32'(err_log_main), 32'h10);
    check("sat_log_shadow", 32'(err_log_shadow), 32'h80);
`endif
    @(posedge clk);
    #1;

    // Reset during RECOVER: word is discarded.
    send(8'h55, 8'hAA, w, ov);
    @(posedge clk);
    #1;
    check("abort_in_recover_pulse", 32'(err_pulse), 32'd1);
    rst = 1'b1;
    #1;
    exp_data_q.delete();
    exp_cnt_q.delete();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    check("abort_err_pulse", 32'(err_pulse), 32'd0);
    check("abort_err_count", 32'(err_count), 32'd0);
`ifdef SAMPLE_EDL_ERRLOG_EN
    check("abort_log_valid", 32'(err_log_valid), 32'd0);
`endif
    h0 = hs_count;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_output", 32'(hs_count - h0), 32'd0);
    check("abort_idle_valid", 32'(out_valid), 32'd0);

    check("sb_data_left", 32'(exp_data_q.size()), 32'd0);
    check("sb_cnt_left", 32'(exp_cnt_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
